// File: rtl/bcd_stream_monitor.sv
// bcd_stream_monitor
//   Checks an incoming valid-qualified BCD digit stream for +1 (mod 10)
//   progression. Locks after LOCK_CNT consecutive correct steps and drops
//   back to hunting after UNLOCK_CNT consecutive bad digits while locked.
//   Flags illegal codes (10..15) and sequence breaks.
//
// Build option:
//   BCD_MON_ERRCNT_EN  defined   -> saturating err_count with synchronous clear
//                      undefined -> err_count tied to 0, clear ignored
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   bcd_in is sampled this cycle
//   bcd_in     incoming digit
//   clear      synchronous clear of err_count
//   locked     high while in LOCKED
//   seq_err    one-cycle pulse, bad digit while LOCKED
//   code_err   one-cycle pulse, illegal code sampled
//   err_count  saturating count of seq_err pulses
//   expected   next expected digit, 0 in IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no history; next legal digit seeds the reference
// HUNT   | reference seeded, counting consecutive correct steps
// LOCKED | stream tracked; mismatches raise seq_err
module bcd_stream_monitor #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 2,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       bcd_in,
   input  logic             clear,
   output logic             locked,
   output logic             seq_err,
   output logic             code_err,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       expected
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_C   = LOCK_CNT[3:0];
   localparam logic [3:0] UNLOCK_C = UNLOCK_CNT[3:0];

   function automatic logic [3:0] bcd_succ(input logic [3:0] v);
      return (v == 4'd9) ? 4'd0 : v + 4'd1;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] ref_q, ref_d;
   logic [3:0] good_q, good_d;
   logic [3:0] bad_q, bad_d;
   logic       seq_d, code_d;
   logic       locked_q, seq_q, code_q;
   logic [3:0] expected_q, expected_d;

   logic       legal;
   logic [3:0] exp_cur;
   logic       match;

   assign legal   = (bcd_in <= 4'd9);
   assign exp_cur = bcd_succ(ref_q);
   assign match   = (bcd_in == exp_cur);

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      good_d  = good_q;
      bad_d   = bad_q;
      seq_d   = 1'b0;
      code_d  = 1'b0;
      if (in_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (legal) begin
                  ref_d   = bcd_in;
                  good_d  = 4'd0;
                  state_d = ST_HUNT;
               end else begin
                  code_d = 1'b1;
               end
            end
            ST_HUNT: begin
               if (!legal) begin
                  code_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (match) begin
                  ref_d  = bcd_in;
                  good_d = good_q + 4'd1;
                  if (good_d == LOCK_C) begin
                     state_d = ST_LOCKED;
                     bad_d   = 4'd0;
                  end
               end else begin
                  // reseed on a legal mismatch; not an error before lock
                  ref_d  = bcd_in;
                  good_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  ref_d = bcd_in;
                  bad_d = 4'd0;
               end else begin
                  seq_d  = 1'b1;
                  code_d = !legal;
                  // illegal codes coast on the predicted digit, legal ones resync
                  ref_d  = legal ? bcd_in : exp_cur;
                  bad_d  = bad_q + 4'd1;
                  if (bad_d == UNLOCK_C) begin
                     state_d = ST_HUNT;
                     good_d  = 4'd0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign expected_d = (state_d == ST_IDLE) ? 4'd0 : bcd_succ(ref_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ref_q      <= 4'd0;
         good_q     <= 4'd0;
         bad_q      <= 4'd0;
         locked_q   <= 1'b0;
         seq_q      <= 1'b0;
         code_q     <= 1'b0;
         expected_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         locked_q   <= (state_d == ST_LOCKED);
         seq_q      <= seq_d;
         code_q     <= code_d;
         expected_q <= expected_d;
      end
   end

   assign locked   = locked_q;
   assign seq_err  = seq_q;
   assign code_err = code_q;
   assign expected = expected_q;

`ifdef BCD_MON_ERRCNT_EN
   logic [ERR_W-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (clear) begin
         err_d = '0;
      end else if (seq_d && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`else
   logic unused_clear;
   assign unused_clear = clear;
   assign err_count    = '0;
`endif

endmodule

// File: tb/tb_bcd_stream_monitor.sv
module tb_bcd_stream_monitor;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] bcd_in;
   logic       clear;

   logic       locked,  seq_err,  code_err;
   logic [7:0] err_count;
   logic [3:0] expected;
   logic       locked2, seq_err2, code_err2;
   logic [1:0] err_count2;
   logic [3:0] expected2;

   bcd_stream_monitor #(.LOCK_CNT(4), .UNLOCK_CNT(2), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd_in), .clear(clear),
      .locked(locked), .seq_err(seq_err), .code_err(code_err),
      .err_count(err_count), .expected(expected)
   );

   bcd_stream_monitor #(.LOCK_CNT(4), .UNLOCK_CNT(2), .ERR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd_in), .clear(clear),
      .locked(locked2), .seq_err(seq_err2), .code_err(code_err2),
      .err_count(err_count2), .expected(expected2)
   );

   typedef struct {
      string      tag;
      logic       l;
      logic       s;
      logic       c;
      logic [3:0] e;
      logic [7:0] n;
      logic [1:0] n2;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0;
   int   m_cnt2 = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   // monitor: one expected record per driven cycle, checked 1 time unit after the edge
   initial begin
      exp_t r;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk({r.tag, " locked"},    locked,     r.l);
            chk({r.tag, " seq_err"},   seq_err,    r.s);
            chk({r.tag, " code_err"},  code_err,   r.c);
            chk({r.tag, " expected"},  expected,   r.e);
            chk({r.tag, " err_count"}, err_count,  r.n);
            chk({r.tag, " locked2"},   locked2,    r.l);
            chk({r.tag, " seq_err2"},  seq_err2,   r.s);
            chk({r.tag, " err_count2"}, err_count2, r.n2);
         end
      end
   end

   task automatic step(input string tag, input logic v, input logic [3:0] d, input logic clr,
                       input logic el, input logic es, input logic ec, input logic [3:0] ee);
      exp_t r;
      @(negedge clk);
      in_valid = v;
      bcd_in   = d;
      clear    = clr;
      if (clr) begin
         m_cnt  = 0;
         m_cnt2 = 0;
      end else if (es) begin
         if (m_cnt  < 255) m_cnt++;
         if (m_cnt2 < 3)   m_cnt2++;
      end
      r.tag = tag;
      r.l = el; r.s = es; r.c = ec; r.e = ee;
`ifdef BCD_MON_ERRCNT_EN
      r.n  = 8'(m_cnt);
      r.n2 = 2'(m_cnt2);
`else
      r.n  = 8'd0;
      r.n2 = 2'd0;
`endif
      sb_q.push_back(r);
   endtask

   task automatic dig(input string tag, input logic [3:0] d,
                      input logic el, input logic es, input logic ec, input logic [3:0] ee);
      step(tag, 1'b1, d, 1'b0, el, es, ec, ee);
   endtask

   task automatic gap(input string tag, input int n, input logic el, input logic [3:0] ee);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 1'b0, el, 1'b0, 1'b0, ee);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " locked"},    locked,    0);
      chk({tag, " seq_err"},   seq_err,   0);
      chk({tag, " code_err"},  code_err,  0);
      chk({tag, " err_count"}, err_count, 0);
      chk({tag, " expected"},  expected,  0);
      chk({tag, " err_count2"}, err_count2, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; bcd_in = 4'd0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // illegal code in IDLE
      dig("idle_ill", 4'd12, 0, 0, 1, 4'd0);
      gap("idle_gap", 1, 0, 4'd0);

      // lock with wrap
      dig("lk7", 4'd7, 0, 0, 0, 4'd8);
      dig("lk8", 4'd8, 0, 0, 0, 4'd9);
      dig("lk9", 4'd9, 0, 0, 0, 4'd0);
      dig("lk0", 4'd0, 0, 0, 0, 4'd1);
      dig("lk1", 4'd1, 1, 0, 0, 4'd2);

      // isolated mismatch and loss of lock
      dig("mm5", 4'd5, 1, 1, 0, 4'd6);
      dig("ok6", 4'd6, 1, 0, 0, 4'd7);
      dig("mm3", 4'd3, 1, 1, 0, 4'd4);
      dig("mm9", 4'd9, 0, 1, 0, 4'd0);

      // relock then illegal code while locked (coast)
      dig("rl0", 4'd0, 0, 0, 0, 4'd1);
      dig("rl1", 4'd1, 0, 0, 0, 4'd2);
      dig("rl2", 4'd2, 0, 0, 0, 4'd3);
      dig("rl3", 4'd3, 1, 0, 0, 4'd4);
      dig("lk_ill", 4'd15, 1, 1, 1, 4'd5);
      dig("coast5", 4'd5, 1, 0, 0, 4'd6);

      // unlock, reseed in HUNT, illegal in HUNT drops to IDLE
      dig("ul8", 4'd8, 1, 1, 0, 4'd9);
      dig("ul2", 4'd2, 0, 1, 0, 4'd3);
      dig("hunt_rs", 4'd7, 0, 0, 0, 4'd8);
      dig("hunt_ill", 4'd11, 0, 0, 1, 4'd0);

      // gapped stream
      dig("g2", 4'd2, 0, 0, 0, 4'd3);
      gap("gap2", 3, 0, 4'd3);
      dig("g3", 4'd3, 0, 0, 0, 4'd4);
      gap("gap3", 3, 0, 4'd4);
      dig("g4", 4'd4, 0, 0, 0, 4'd5);
      gap("gap4", 3, 0, 4'd5);
      dig("g5", 4'd5, 0, 0, 0, 4'd6);
      gap("gap5", 3, 0, 4'd6);
      dig("g6", 4'd6, 1, 0, 0, 4'd7);
      gap("gap6", 3, 1, 4'd7);

      // clear wins over a simultaneous seq_err
      step("clr_mm", 1'b1, 4'd1, 1'b1, 1, 1, 0, 4'd2);
      dig("post_clr", 4'd2, 1, 0, 0, 4'd3);

      // five mismatches, relocking between pairs (ERR_W=2 instance saturates)
      dig("s1", 4'd9, 1, 1, 0, 4'd0);
      dig("s2", 4'd9, 0, 1, 0, 4'd0);
      dig("r0", 4'd0, 0, 0, 0, 4'd1);
      dig("r1", 4'd1, 0, 0, 0, 4'd2);
      dig("r2", 4'd2, 0, 0, 0, 4'd3);
      dig("r3", 4'd3, 1, 0, 0, 4'd4);
      dig("s3", 4'd8, 1, 1, 0, 4'd9);
      dig("s4", 4'd8, 0, 1, 0, 4'd9);
      dig("q9", 4'd9, 0, 0, 0, 4'd0);
      dig("q0", 4'd0, 0, 0, 0, 4'd1);
      dig("q1", 4'd1, 0, 0, 0, 4'd2);
      dig("q2", 4'd2, 1, 0, 0, 4'd3);
      dig("s5", 4'd7, 1, 1, 0, 4'd8);
      dig("ok8", 4'd8, 1, 0, 0, 4'd9);

      // asynchronous reset mid-stream
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      m_cnt  = 0;
      m_cnt2 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      dig("seed4", 4'd4, 0, 0, 0, 4'd5);
      dig("seed5", 4'd5, 0, 0, 0, 4'd6);
      gap("tail", 1, 0, 4'd6);

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_stream_monitor.md
# bcd_stream_monitor

Sequence checker for the receiving end of a BCD counter stream. It samples valid-qualified BCD digits and checks that each digit is the previous digit plus one, modulo 10. It acquires lock after a run of correct steps, drops lock after repeated mismatches, and reports code and sequence errors. It sits downstream of the BCD sequence generators as a self-check and link-integrity monitor.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive correct steps needed to enter LOCKED (valid range 1..15).
- UNLOCK_CNT, 2: consecutive bad digits in LOCKED needed to fall back to HUNT (valid range 1..15).
- ERR_W, 8: width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  bcd_in is sampled on this cycle.
- bcd_in  input  4  incoming digit; values 10..15 are illegal codes.
- clear  input  1  synchronous clear of err_count.
- locked  output  1  high while the state is LOCKED.
- seq_err  output  1  one-cycle pulse: a bad digit was seen while LOCKED.
- code_err  output  1  one-cycle pulse: an illegal code was sampled in any state.
- err_count  output  ERR_W  saturating count of seq_err events.
- expected  output  4  next digit expected; 0 in IDLE.

## Operation
- States are IDLE, HUNT and LOCKED.
- ref holds the last accepted digit. The expected digit is (ref == 9) ? 0 : ref + 1.
- Internal counters good_cnt and bad_cnt are each 4 bits wide.
- No state change occurs on cycles where in_valid is 0. On those cycles seq_err and code_err are 0.

IDLE:
- Legal digit d: ref <= d, good_cnt <= 0, go to HUNT.
- Illegal code: pulse code_err, stay in IDLE.

HUNT:
- d == expected: ref <= d, good_cnt++. When good_cnt reaches LOCK_CNT: go to LOCKED, bad_cnt <= 0.
- Legal mismatch: ref <= d (reseed), good_cnt <= 0. No seq_err.
- Illegal code: pulse code_err, go to IDLE.

LOCKED:
- d == expected: ref <= d, bad_cnt <= 0.
- Legal mismatch: pulse seq_err, ref <= d (resync), bad_cnt++.
- Illegal code: pulse code_err and seq_err, ref <= expected (coast), bad_cnt++.
- When bad_cnt reaches UNLOCK_CNT: go to HUNT, good_cnt <= 0. The ref update still applies on that cycle.

err_count:
- Increments on every seq_err pulse.
- Saturates at 2^ERR_W - 1.
- clear zeroes it and wins over a simultaneous increment.
- clear has no effect on the FSM, ref or the other counters.

## Timing
- All outputs are registered and update on the clk edge that samples in_valid. Response latency is 1 cycle.
- locked rises on the edge that samples the LOCK_CNT-th consecutive correct step.
- locked falls on the edge that samples the UNLOCK_CNT-th consecutive bad digit.
- seq_err and code_err are high for exactly one cycle per offending sample. Back-to-back bad samples give back-to-back pulses.
- Wrap-around: 9 followed by 0 is a correct step. 9 followed by 10 is an illegal code, not a step.
- Reset (asynchronous assert, synchronous release):
  - state is IDLE; ref, good_cnt and bad_cnt are 0;
  - locked, seq_err, code_err, err_count and expected are 0.
- Reset asserted mid-stream discards all history. The first valid digit after release reseeds the monitor.

## Configuration
- Macro BCD_MON_ERRCNT_EN.
  - Defined: err_count is implemented as described above.
  - Undefined: the err_count register and clear logic are removed, err_count is tied to 0, and clear is ignored.
- The FSM, seq_err and code_err are identical in both builds.

## Test plan
All scenarios use the defaults LOCK_CNT=4 and UNLOCK_CNT=2, and send one digit per cycle unless stated otherwise.

- **Lock with wrap:** send 7,8,9,0,1 -> locked rises on the edge that samples 1. expected is 2 afterwards. seq_err is never asserted.
- **Isolated mismatch and loss of lock:**
  - Stimulus: after lock on 1, send 5.
  - Response: seq_err pulses, err_count=1, locked stays 1, expected=6.
  - Then send 6 -> no error. Then send 3,9 -> two seq_err pulses, err_count=3, locked falls on the edge that samples 9.
- **Illegal codes:**
  - In IDLE, send 12 -> code_err pulses, state remains IDLE, expected=0.
  - In LOCKED with expected=4, send 15 -> code_err and seq_err pulse together, expected=5.
- **Gapped stream and clear:**
  - Stimulus: digits 2,3,4,5,6 with in_valid low for 3 cycles between each.
  - Response: locked rises on the edge that samples 6. No output changes occur on idle cycles.
  - Then assert clear in the same cycle as a mismatch -> err_count=0.
- **Saturation and reset:**
  - With ERR_W=2, force 5 mismatches while LOCKED, re-locking between pairs -> err_count holds at 3.
  - Assert rst_n low mid-stream -> all outputs are 0 immediately, and the next digit seeds HUNT.
- **Build variant:** with BCD_MON_ERRCNT_EN undefined, rerun the loss-of-lock scenario -> err_count stays 0, and the seq_err and locked waveforms match the enabled build.
